// File: rtl/cmmdc_dispatch.sv
// rtl/cmmdc_dispatch.sv - operand FIFO and start/ack dispatcher feeding the cmmdc GCD core
// Optional feature macro: CMMDC_TIMEOUT_EN (WAIT-state watchdog, aborts with out_err=1)
module cmmdc_dispatch #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
`ifdef CMMDC_TIMEOUT_EN
  ,
  parameter int TMO   = 600
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  output logic         gcd_start,
  output logic [W-1:0] gcd_x,
  output logic [W-1:0] gcd_y,
  input  logic [W-1:0] gcd_r,
  input  logic         gcd_ack,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y,
  output logic         out_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]   state;
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] fifo_x [DEPTH];
  logic [W-1:0] fifo_y [DEPTH];
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic [W-1:0] head_x;
  logic [W-1:0] head_y;
  logic         ack_q;
  logic         stale;
  logic         rise;
  logic         tmo_hit;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == IDLE) && !empty;
  assign head_x   = fifo_x[rd_ptr[AW-1:0]];
  assign head_y   = fifo_y[rd_ptr[AW-1:0]];
  // A result is taken only on the 0->1 edge of ack, so a level left over from an
  // earlier operation cannot be mistaken for a new one.
  assign rise     = gcd_ack && !ack_q;

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x[wr_ptr[AW-1:0]] <= in_x;
      fifo_y[wr_ptr[AW-1:0]] <= in_y;
    end
  end

  // FIFO pointers, one extra wrap bit to tell full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Stale-result flag: the core has no reset, so it survives rst and marks the next ack rise as garbage
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == ISSUE || state == WAIT) stale <= 1'b1;
    end else if (state == WAIT) begin
      if (rise)         stale <= 1'b0;
      else if (tmo_hit) stale <= 1'b1;
    end
  end

  // Dispatch FSM: pop, bypass zero operands or issue to the core, capture, hold for consumer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gcd_start <= 1'b0;
      gcd_x     <= '0;
      gcd_y     <= '0;
      ack_q     <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      gcd_start <= 1'b0;
      ack_q     <= gcd_ack;
      case (state)
        IDLE: begin
          if (!empty) begin
            out_x <= head_x;
            out_y <= head_y;
            if (head_x == '0 || head_y == '0) begin
              // The core never terminates on a zero input; gcd(0,n)=n and gcd(0,0)=0.
              out_r     <= head_x | head_y;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              gcd_x     <= head_x;
              gcd_y     <= head_y;
              gcd_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          ack_q <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (rise) begin
            if (stale) begin
              gcd_start <= 1'b1;
              state     <= ISSUE;
            end else begin
              out_r     <= gcd_r;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end else if (tmo_hit) begin
            out_r     <= '0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CMMDC_TIMEOUT_EN
  logic [9:0] wd_cnt;
  logic       err_q;

  assign tmo_hit = (state == WAIT) && (wd_cnt >= 10'(TMO));
  assign out_err = err_q;

  // Watchdog: restarts on every issue, counts WAIT cycles, saturates at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= '0;
    end else if (state == WAIT && wd_cnt != 10'h3FF) begin
      wd_cnt <= wd_cnt + 10'd1;
    end
  end

  // Error flag travels with the aborted result and clears when it is consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == WAIT && !rise && tmo_hit) begin
      err_q <= 1'b1;
    end else if (state == HOLD && out_ready) begin
      err_q <= 1'b0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmmdc_dispatch.sv
// tb/tb_cmmdc_dispatch.sv - randomized self-checking bench for cmmdc_dispatch with a behavioural GCD core
module tb_cmmdc_dispatch;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] r;
    logic         err;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic         gcd_start;
  logic [W-1:0] gcd_x;
  logic [W-1:0] gcd_y;
  logic [W-1:0] gcd_r;
  logic         gcd_ack;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_r;
  logic [W-1:0] out_x;
  logic [W-1:0] out_y;
  logic         out_err;

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  cmmdc_dispatch #(
    .W(W), .DEPTH(4), .AW(2)
`ifdef CMMDC_TIMEOUT_EN
    , .TMO(20)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .gcd_start(gcd_start), .gcd_x(gcd_x), .gcd_y(gcd_y), .gcd_r(gcd_r), .gcd_ack(gcd_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_x(out_x), .out_y(out_y),
    .out_err(out_err)
  );

  // Core stand-in: subtractive GCD, no reset, ignores start while busy, ack level held until next start
  logic         core_busy = 1'b0;
  logic         core_ack = 1'b0;
  logic [W-1:0] core_a = '0;
  logic [W-1:0] core_b = '0;
  logic [W-1:0] core_r = '0;
  assign gcd_r   = core_r;
  assign gcd_ack = core_ack;

  always @(posedge clk) begin
    if (gcd_start && !core_busy) begin
      core_a    <= gcd_x;
      core_b    <= gcd_y;
      core_busy <= 1'b1;
      core_ack  <= 1'b0;
    end else if (core_busy) begin
      if (core_a == core_b) begin
        core_r    <= core_a;
        core_ack  <= 1'b1;
        core_busy <= 1'b0;
      end else if (core_a > core_b) begin
        core_a <= core_a - core_b;
      end else begin
        core_b <= core_b - core_a;
      end
    end
  end

  // Start pulse observers
  int   start_cnt = 0;
  int   double_pulse = 0;
  logic start_prev = 1'b0;
  always @(posedge clk) begin
    start_prev <= gcd_start;
    if (gcd_start) start_cnt <= start_cnt + 1;
    if (gcd_start && start_prev) double_pulse <= double_pulse + 1;
  end

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic [W-1:0] t;
    p = a;
    q = b;
    while (q != '0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  task automatic model_add(input logic [W-1:0] x, input logic [W-1:0] y);
    res_t e;
    e.x = x; e.y = y; e.r = ref_gcd(x, y); e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  // Offer one pair (called at a negedge); returns whether it was taken
  task automatic push(input logic [W-1:0] x, input logic [W-1:0] y, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1; in_x = x; in_y = y;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    if (ok) model_add(x, y);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (gcd_start !== 1'b0) begin failures++; $display("FAIL reset_gcd_start: got %0b want 0", gcd_start); end
    checks++; if (gcd_x !== '0)       begin failures++; $display("FAIL reset_gcd_x: got %0d want 0", gcd_x); end
    checks++; if (gcd_y !== '0)       begin failures++; $display("FAIL reset_gcd_y: got %0d want 0", gcd_y); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if ({out_r, out_x, out_y} !== '0) begin failures++; $display("FAIL reset_out_data: got r=%0d x=%0d y=%0d want 0", out_r, out_x, out_y); end
    checks++; if (out_err !== 1'b0)   begin failures++; $display("FAIL reset_out_err: got %0b want 0", out_err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_core_path;
    int   s0;
    int   t;
    bit   ok;
    res_t e;
    s0 = start_cnt;
    out_ready = 1'b1;
    push(8'd2, 8'd4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL core_push: accepted=%0b want 1", ok); end
    t = 0;
    while (!out_valid && t < 3000) begin @(negedge clk); t++; end
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_r, out_x, out_y, out_err} !== {e.r, e.x, e.y, e.err}) begin
      failures++;
      $display("FAIL core_result: got v=%0b r=%0d x=%0d y=%0d err=%0b want r=%0d x=%0d y=%0d err=%0b",
               out_valid, out_r, out_x, out_y, out_err, e.r, e.x, e.y, e.err);
    end
    @(negedge clk);
    checks++; if (start_cnt - s0 != 1) begin failures++; $display("FAIL core_start_count: got %0d want 1", start_cnt - s0); end
    checks++; if (double_pulse != 0)   begin failures++; $display("FAIL core_pulse_width: got %0d wide pulses want 0", double_pulse); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] xs [4];
    logic [W-1:0] ys [4];
    xs[0] = 8'd12;  ys[0] = 8'd18;
    xs[1] = 8'd35;  ys[1] = 8'd14;
    xs[2] = 8'd7;   ys[2] = 8'd7;
    xs[3] = 8'd255; ys[3] = 8'd1;
    out_ready = 1'b1;
    fork
      begin
        bit ok;
        for (int i = 0; i < 4; i++) begin
          checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d]: got %0b want 1", i, in_ready); end
          push(xs[i], ys[i], ok);
        end
      end
      begin
        int   t;
        res_t e;
        for (int i = 0; i < 4; i++) begin
          t = 0;
          while (!(out_valid && exp_q.size() != 0) && t < 3000) begin @(negedge clk); t++; end
          checks++;
          if (!out_valid || exp_q.size() == 0) begin
            failures++; $display("FAIL b2b_timeout[%0d]: out_valid=%0b want 1", i, out_valid);
          end else begin
            e = exp_q.pop_front();
            if ({out_r, out_x, out_y, out_err} !== {e.r, e.x, e.y, e.err}) begin
              failures++;
              $display("FAIL b2b_result[%0d]: got r=%0d x=%0d y=%0d err=%0b want r=%0d x=%0d y=%0d err=%0b",
                       i, out_r, out_x, out_y, out_err, e.r, e.x, e.y, e.err);
            end
          end
          @(negedge clk);
        end
      end
    join
  endtask

  task automatic test_zero_bypass;
    int   s0;
    int   t;
    bit   ok;
    res_t e;
    s0 = start_cnt;
    out_ready = 1'b1;
    push(8'd0, 8'd9, ok);
    push(8'd0, 8'd0, ok);
    for (int i = 0; i < 2; i++) begin
      t = 0;
      while (!out_valid && t < 50) begin @(negedge clk); t++; end
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {out_r, out_x, out_y, out_err} !== {e.r, e.x, e.y, e.err}) begin
        failures++;
        $display("FAIL zero_result[%0d]: got v=%0b r=%0d x=%0d y=%0d want r=%0d x=%0d y=%0d",
                 i, out_valid, out_r, out_x, out_y, e.r, e.x, e.y);
      end
      @(negedge clk);
    end
    checks++; if (start_cnt != s0) begin failures++; $display("FAIL zero_no_start: got %0d starts want 0", start_cnt - s0); end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] xs [6];
    logic [W-1:0] ys [6];
    logic [3*W:0] held;
    int           accepted;
    int           t;
    res_t         e;
    accepted = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      xs[i] = W'($urandom_range(1, 60));
      ys[i] = W'($urandom_range(1, 60));
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_x = xs[i]; in_y = ys[i];
      for (int k = 0; k < 4; k++) begin
        if (in_ready) begin
          accepted++;
          model_add(xs[i], ys[i]);
          @(negedge clk);
          break;
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    checks++; if (accepted != 5)     begin failures++; $display("FAIL bp_accepted: got %0d want 5", accepted); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full: in_ready got %0b want 0", in_ready); end
    t = 0;
    while (!out_valid && t < 3000) begin @(negedge clk); t++; end
    held = {out_r, out_x, out_y, out_err};
    repeat (5) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {out_r, out_x, out_y, out_err} !== held) begin
      failures++; $display("FAIL bp_hold: got v=%0b data=%h want v=1 data=%h", out_valid, {out_r, out_x, out_y, out_err}, held);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      t = 0;
      while (!out_valid && t < 3000) begin @(negedge clk); t++; end
      checks++;
      if (!out_valid || exp_q.size() == 0) begin
        failures++; $display("FAIL bp_timeout[%0d]: out_valid=%0b want 1", i, out_valid);
      end else begin
        e = exp_q.pop_front();
        if ({out_r, out_x, out_y, out_err} !== {e.r, e.x, e.y, e.err}) begin
          failures++;
          $display("FAIL bp_result[%0d]: got r=%0d x=%0d y=%0d want r=%0d x=%0d y=%0d", i, out_r, out_x, out_y, e.r, e.x, e.y);
        end
      end
      @(negedge clk);
    end
    t = 0;
    while (!out_valid && t < 300) begin @(negedge clk); t++; end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra: out_valid got %0b want 0 (refused push stored)", out_valid); end
  endtask

  task automatic test_reset_mid_wait;
    int   s0;
    int   t;
    bit   ok;
    res_t e;
    s0 = start_cnt;
    out_ready = 1'b1;
    push(8'd200, 8'd3, ok);
    t = 0;
    while (start_cnt == s0 && t < 50) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rmw_after_reset: out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready); end
    push(8'd8, 8'd12, ok);
    t = 0;
    while (!out_valid && t < 3000) begin @(negedge clk); t++; end
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_r, out_x, out_y, out_err} !== {e.r, e.x, e.y, e.err}) begin
      failures++;
      $display("FAIL rmw_result: got v=%0b r=%0d x=%0d y=%0d want r=%0d x=%0d y=%0d", out_valid, out_r, out_x, out_y, e.r, e.x, e.y);
    end
    @(negedge clk);
    t = 0;
    while (!out_valid && t < 300) begin @(negedge clk); t++; end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmw_extra: got out_valid=%0b r=%0d want no result", out_valid, out_r); end
  endtask

  task automatic test_random;
    int n;
    n = 20;
    fork
      begin
        bit           ok;
        logic [W-1:0] x;
        logic [W-1:0] y;
        for (int i = 0; i < n; i++) begin
          x = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
          y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
          push(x, y, ok);
          checks++; if (!ok) begin failures++; $display("FAIL rnd_push[%0d]: accepted=%0b want 1", i, ok); end
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        int           got;
        int           t;
        bit           was;
        logic [3*W:0] held;
        res_t         e;
        got = 0; t = 0; was = 1'b0; held = '0;
        while (got < n && t < 20000) begin
          out_ready = ($urandom_range(0, 2) != 0);
          if (was) begin
            checks++;
            if (out_valid !== 1'b1 || {out_r, out_x, out_y, out_err} !== held) begin
              failures++; $display("FAIL rnd_stable: got v=%0b data=%h want v=1 data=%h", out_valid, {out_r, out_x, out_y, out_err}, held);
            end
          end
          was = 1'b0;
          if (out_valid) begin
            if (out_ready) begin
              checks++;
              if (exp_q.size() == 0) begin
                failures++; $display("FAIL rnd_unexpected: got r=%0d x=%0d y=%0d want no result", out_r, out_x, out_y);
              end else begin
                e = exp_q.pop_front();
                if ({out_r, out_x, out_y, out_err} !== {e.r, e.x, e.y, e.err}) begin
                  failures++;
                  $display("FAIL rnd_result[%0d]: got r=%0d x=%0d y=%0d err=%0b want r=%0d x=%0d y=%0d err=%0b",
                           got, out_r, out_x, out_y, out_err, e.r, e.x, e.y, e.err);
                end
              end
              got++;
            end else begin
              held = {out_r, out_x, out_y, out_err};
              was = 1'b1;
            end
          end
          @(negedge clk);
          t++;
        end
        checks++; if (got != n) begin failures++; $display("FAIL rnd_count: got %0d results want %0d", got, n); end
      end
    join
    out_ready = 1'b1;
  endtask

`ifdef CMMDC_TIMEOUT_EN
  task automatic test_timeout;
    int   t;
    bit   ok;
    res_t e;
    out_ready = 1'b1;
    push(8'd255, 8'd1, ok);
    exp_q[exp_q.size()-1].r   = '0;
    exp_q[exp_q.size()-1].err = 1'b1;
    push(8'd9, 8'd6, ok);
    for (int i = 0; i < 2; i++) begin
      t = 0;
      while (!out_valid && t < 3000) begin @(negedge clk); t++; end
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {out_r, out_x, out_y, out_err} !== {e.r, e.x, e.y, e.err}) begin
        failures++;
        $display("FAIL tmo_result[%0d]: got v=%0b r=%0d x=%0d y=%0d err=%0b want r=%0d x=%0d y=%0d err=%0b",
                 i, out_valid, out_r, out_x, out_y, out_err, e.r, e.x, e.y, e.err);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset;
    test_core_path;
    test_zero_bypass;
`ifdef CMMDC_TIMEOUT_EN
    test_timeout;
`else
    test_back_to_back;
    test_backpressure;
    test_reset_mid_wait;
    test_random;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
